// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one 16-bit bitwise logic unit among NUM_REQ requesters.
// Operands are latched on grant, the result is registered, and responses use valid/ready.
module logic16_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       busy
);

    localparam int          IDW  = $clog2(NUM_REQ);
    localparam int unsigned NREQ = NUM_REQ;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [1:0]       cur_op;
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [WIDTH-1:0] result;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               found;
    int unsigned        idx;

    // Rotating-priority scan: first valid index at or after ptr, wrapping past NUM_REQ-1.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        sel_op   = '0;
        sel_a    = '0;
        sel_b    = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
                sel_op      = req_op[2*idx +: 2];
                sel_a       = req_a[WIDTH*idx +: WIDTH];
                sel_b       = req_b[WIDTH*idx +: WIDTH];
            end
        end
    end

    assign req_ready = (state == IDLE && reset_n) ? grant : '0;

    always_comb begin
        result = '0;
        case (cur_op)
            2'b00:   result = cur_a & cur_b;
            2'b01:   result = cur_a | cur_b;
            2'b10:   result = cur_a ^ cur_b;
            default: result = ~cur_a;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_op    <= '0;
            cur_a     <= '0;
            cur_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= EXEC;
                        busy   <= 1'b1;
                        cur_op <= sel_op;
                        cur_a  <= sel_a;
                        cur_b  <= sel_b;
                        rsp_id <= grant_id;
                    end
                end
                EXEC: begin
                    rsp_data  <= result;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        ptr       <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic16_arbiter.sv
// Scoreboard bench for logic16_arbiter: stimulus queues expected {id,data},
// a negedge monitor pops and compares on every accepted response.
module tb_logic16_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_grant_cyc = 0;
    logic [17:0] sb[$];

    logic16_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response must match the oldest queued expectation.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got id=%0d data=%h expected none", rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e[17:16]));
                    chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        req_op[2*id +: 2]  = op;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Waits (bounded) for a grant, checks winner and optional 3-cycle spacing, then passes the grant edge.
    task automatic watch_grant(input int id, input bit chk_space);
        int n = 0;
        logic [3:0] expg;
        expg = 4'b0001 << id;
        forever begin
            @(negedge clk);
            if (req_ready != 4'b0000 || n >= 20) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk("grant", 32'(req_ready), 32'(expg));
        if (chk_space) chk("grant_spacing", 32'(cyc - last_grant_cyc), 32'd3);
        last_grant_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int id, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] expd);
        int n;
        logic [3:0] expg;
        expg = 4'b0001 << id;
        set_req(id, op, a, b);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        @(negedge clk);
        chk("single_grant", 32'(req_ready), 32'(expg));
        sb.push_back({2'(id), expd});
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 1;
        forever begin
            @(negedge clk);
            if (rsp_valid || n >= 10) break;
            @(posedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd2);
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op, then op coverage; ends with ptr back at 0.
        do_op(0, 2'b00, 16'hF0F0, 16'h3C3C, 16'h3030);
        do_op(1, 2'b01, 16'hAAAA, 16'h0FF0, 16'hAFFA);
        do_op(2, 2'b10, 16'hAAAA, 16'h0FF0, 16'hA55A);
        do_op(3, 2'b11, 16'hAAAA, 16'h0FF0, 16'h5555);

        // Contention: all four held, order 0,1,2,3,0 including ptr wrap.
        set_req(0, 2'b00, 16'h1234, 16'h00FF);
        set_req(1, 2'b01, 16'h5678, 16'h00FF);
        set_req(2, 2'b10, 16'h9ABC, 16'h00FF);
        set_req(3, 2'b11, 16'hDEF0, 16'h00FF);
        sb.push_back({2'd0, 16'h0034});
        sb.push_back({2'd1, 16'h56FF});
        sb.push_back({2'd2, 16'h9A43});
        sb.push_back({2'd3, 16'h210F});
        sb.push_back({2'd0, 16'h0034});
        req_valid = 4'b1111;
        watch_grant(0, 1'b0);
        watch_grant(1, 1'b1);
        watch_grant(2, 1'b1);
        watch_grant(3, 1'b1);
        watch_grant(0, 1'b1);
        req_valid = '0;
        wait_drain();

        // Backpressure with ptr=1: req1 wins, req3 waits until acceptance.
        rsp_ready = 1'b0;
        set_req(1, 2'b00, 16'hFFFF, 16'h00FF);
        set_req(3, 2'b01, 16'h0F00, 16'h00F0);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 32'b0010);
        sb.push_back({2'd1, 16'h00FF});
        sb.push_back({2'd3, 16'h0FF0});
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'h00FF);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        last_grant_cyc = cyc;
        watch_grant(3, 1'b0);
        req_valid = '0;
        wait_drain();

        // Reset during EXEC with ptr=3; the killed op must never respond.
        do_op(2, 2'b10, 16'hFF00, 16'h0F0F, 16'hF00F);
        set_req(2, 2'b00, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("pre_rst_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // Fairness: req1/req3 held; first grant 1 shows ptr=0, then ptr=2 gives 3,1,3.
        set_req(1, 2'b01, 16'hF000, 16'h000F);
        set_req(3, 2'b11, 16'h1234, 16'hFFFF);
        sb.push_back({2'd1, 16'hF00F});
        sb.push_back({2'd3, 16'hEDCB});
        sb.push_back({2'd1, 16'hF00F});
        sb.push_back({2'd3, 16'hEDCB});
        req_valid = 4'b1010;
        watch_grant(1, 1'b0);
        watch_grant(3, 1'b1);
        watch_grant(1, 1'b1);
        watch_grant(3, 1'b1);
        req_valid = '0;
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
